sram_ctrl: RTL and testbench

Responder for the SRAM window (addr[23:22] == 2'b10) of the 24-bit memory map. It accepts single 16-bit read/write requests from the address decoder/bus master over a req/ack handshake and drives an external asynchronous SRAM with programmable wait states. The bidirectional data bus is split into in, out and output-enable signals; the top level owns the tristate buffer.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/sram_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the 24-bit memory map responders.
//   REGION_*     : addr[23:22] codes that select each window
//   sram_state_t : sequencing states of the SRAM responder
//   WS_CNT_W     : width of the wait-state down-counter (wait states 1..15)
package mem_pkg;

    localparam logic [1:0] REGION_SDRM = 2'b00;
    localparam logic [1:0] REGION_FLSH = 2'b01;
    localparam logic [1:0] REGION_SRAM = 2'b10;
    localparam logic [1:0] REGION_REGS = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } sram_state_t;

    localparam int WS_CNT_W = 4;

endpackage

// File: rtl/sram_ctrl.sv
// SRAM window responder: turns one req/ack bus transaction into a timed
// access on an external asynchronous SRAM with programmable wait states.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   sel, req          : window select and level request (sampled in IDLE only)
//   we, addr, be      : direction, word address, byte enables ([1] upper)
//   wr_data, rd_data  : write data in, read data out (held until next read)
//   ack, busy         : one-cycle completion pulse, transaction in flight
//   sram_a            : SRAM word address
//   sram_d_i/o, _oe   : split bidirectional data bus, top level owns the pad
//   sram_*_n          : active-low chip/output/write/upper/lower strobes
//
// Handshake: a request is accepted on the edge where the block is in IDLE
// with req & sel high; ack pulses for exactly one cycle when the access is
// complete and busy falls the cycle after. Holding req high through ack
// starts the next transaction immediately.
//
// Every output is a flop. The output process computes the values the pins
// must carry in the next state, and the state register loads them together
// with the state, so the pins change in the same cycle the state does.
module sram_ctrl
    import mem_pkg::*;
#(
    parameter int AW    = 20,
    parameter int RD_WS = 1,
    parameter int WR_WS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          req,
    input  logic          we,
    input  logic [21:0]   addr,
    input  logic [1:0]    be,
    input  logic [15:0]   wr_data,
    output logic [15:0]   rd_data,
    output logic          ack,
    output logic          busy,
    output logic [AW-1:0] sram_a,
    input  logic [15:0]   sram_d_i,
    output logic [15:0]   sram_d_o,
    output logic          sram_d_oe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    // A read spends RD_WS+1 cycles in ACCESS and a write WR_WS, so the
    // counter is loaded one lower for writes; ACCESS exits when it hits 0.
    localparam logic [WS_CNT_W-1:0] RD_LOAD = WS_CNT_W'(RD_WS);
    localparam logic [WS_CNT_W-1:0] WR_LOAD = WS_CNT_W'(WR_WS - 1);

    sram_state_t         state;
    sram_state_t         state_next;
    logic [WS_CNT_W-1:0] cnt;
    logic [WS_CNT_W-1:0] cnt_next;
    logic                accept;
    logic                capture;

    logic                we_q;
    logic [1:0]          be_q;
    logic                txn_we;
    logic [1:0]          txn_be;

    logic                ce_n_nx;
    logic                oe_n_nx;
    logic                we_n_nx;
    logic                ub_n_nx;
    logic                lb_n_nx;
    logic                d_oe_nx;
    logic                ack_nx;
    logic                busy_nx;

    // Only the low AW address bits reach the device; the window itself is
    // decoded upstream into sel.
    logic                unused_addr;
    assign unused_addr = ^addr;

    // State, counter, latched request and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            be_q      <= 2'b00;
            sram_a    <= '0;
            sram_d_o  <= '0;
            rd_data   <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            sram_d_oe <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            ack       <= ack_nx;
            busy      <= busy_nx;
            sram_d_oe <= d_oe_nx;
            sram_ce_n <= ce_n_nx;
            sram_oe_n <= oe_n_nx;
            sram_we_n <= we_n_nx;
            sram_ub_n <= ub_n_nx;
            sram_lb_n <= lb_n_nx;
            if (accept) begin
                we_q   <= we;
                be_q   <= be;
                sram_a <= addr[AW-1:0];
                if (we) begin
                    sram_d_o <= wr_data;
                end
            end
            // Only a read that reaches the end of ACCESS updates rd_data;
            // an aborted read leaves the previous value in place.
            if (capture) begin
                rd_data <= sram_d_i;
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req && sel) begin
                    accept     = 1'b1;
                    state_next = we ? SETUP : ACCESS;
                    cnt_next   = we ? WR_LOAD : RD_LOAD;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_next = DONE;
                    capture    = ~we_q;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pin values for the state being entered. On the accepting edge the
    // request fields are not latched yet, so take them from the bus.
    assign txn_we = accept ? we : we_q;
    assign txn_be = accept ? be : be_q;

    always_comb begin
        ce_n_nx = 1'b1;
        oe_n_nx = 1'b1;
        we_n_nx = 1'b1;
        ub_n_nx = 1'b1;
        lb_n_nx = 1'b1;
        d_oe_nx = 1'b0;
        ack_nx  = 1'b0;
        busy_nx = (state_next != IDLE);
        case (state_next)
            SETUP: begin
                ce_n_nx = 1'b0;
                d_oe_nx = 1'b1;
                ub_n_nx = ~txn_be[1];
                lb_n_nx = ~txn_be[0];
            end
            ACCESS: begin
                ce_n_nx = 1'b0;
                if (txn_we) begin
                    we_n_nx = 1'b0;
                    d_oe_nx = 1'b1;
                    ub_n_nx = ~txn_be[1];
                    lb_n_nx = ~txn_be[0];
                end else begin
                    // Reads always fetch the whole word.
                    oe_n_nx = 1'b0;
                    ub_n_nx = 1'b0;
                    lb_n_nx = 1'b0;
                end
            end
            DONE: begin
                // Write: we_n rises while data, address and ce_n are still
                // driven, giving the SRAM its data-hold cycle.
                ack_nx  = 1'b1;
                ce_n_nx = 1'b0;
                if (txn_we) begin
                    d_oe_nx = 1'b1;
                    ub_n_nx = ~txn_be[1];
                    lb_n_nx = ~txn_be[0];
                end else begin
                    ub_n_nx = 1'b0;
                    lb_n_nx = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl. Three instances cover the wait-state settings used by
// the directed cases: u0 RD_WS=1/WR_WS=1, u1 RD_WS=3/WR_WS=2,
// u2 RD_WS=1/WR_WS=4. Each has its own small SRAM model.
// Stimulus pushes the expected acks and the expected pin values for given
// cycles; a monitor on the falling edge pops and compares them.
module tb_sram_ctrl;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] cyc;
        logic        is_rd;
        logic [15:0] data;
    } ack_exp_t;

    // pins = {ce_n, oe_n, we_n, ub_n, lb_n, d_oe, busy}; mask[7] checks sram_a
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] cyc;
        logic [7:0]  mask;
        logic [6:0]  pins;
        logic [19:0] a;
    } pin_exp_t;

    localparam logic [7:0] M_ALL  = 8'hFF;
    localparam logic [7:0] M_PINS = 8'h7F;
    localparam logic [7:0] M_BUSY = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cyc = 32'd0;

    logic [2:0]  sel, req, we, ack, busy, sram_d_oe;
    logic [2:0]  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [21:0] addr [3];
    logic [1:0]  be [3];
    logic [15:0] wr_data [3];
    logic [15:0] rd_data [3];
    logic [15:0] sram_d_i [3];
    logic [15:0] sram_d_o [3];
    logic [19:0] sram_a [3];

    ack_exp_t    ack_q[$];
    pin_exp_t    pin_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RDW = (g == 1) ? 3 : 1;
        localparam int WRW = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [15:0] mem [256];

        sram_ctrl #(.AW(20), .RD_WS(RDW), .WR_WS(WRW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .sel       (sel[g]),
            .req       (req[g]),
            .we        (we[g]),
            .addr      (addr[g]),
            .be        (be[g]),
            .wr_data   (wr_data[g]),
            .rd_data   (rd_data[g]),
            .ack       (ack[g]),
            .busy      (busy[g]),
            .sram_a    (sram_a[g]),
            .sram_d_i  (sram_d_i[g]),
            .sram_d_o  (sram_d_o[g]),
            .sram_d_oe (sram_d_oe[g]),
            .sram_ce_n (sram_ce_n[g]),
            .sram_oe_n (sram_oe_n[g]),
            .sram_we_n (sram_we_n[g]),
            .sram_ub_n (sram_ub_n[g]),
            .sram_lb_n (sram_lb_n[g])
        );

        // SRAM model: byte-lane writes while ce_n and we_n are low, reads
        // driven while ce_n and oe_n are low. Cleared by rst.
        assign sram_d_i[g] = (!sram_ce_n[g] && !sram_oe_n[g]) ? mem[sram_a[g][7:0]] : 16'h0000;

        always @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < 256; j++) mem[j] <= 16'h0000;
            end else if (!sram_ce_n[g] && !sram_we_n[g]) begin
                if (!sram_ub_n[g]) mem[sram_a[g][7:0]][15:8] <= sram_d_o[g][15:8];
                if (!sram_lb_n[g]) mem[sram_a[g][7:0]][7:0]  <= sram_d_o[g][7:0];
            end
        end
    end

    function automatic logic [6:0] pv(input logic ce, input logic oe, input logic w,
                                      input logic ub, input logic lb, input logic doe,
                                      input logic bsy);
        return {ce, oe, w, ub, lb, doe, bsy};
    endfunction

    task automatic push_ack(input int i, input logic [31:0] c, input logic is_rd,
                            input logic [15:0] d);
        ack_exp_t e;
        e.id = 2'(i); e.cyc = c; e.is_rd = is_rd; e.data = d;
        ack_q.push_back(e);
    endtask

    task automatic push_pin(input int i, input logic [31:0] c, input logic [7:0] m,
                            input logic [6:0] p, input logic [19:0] a);
        pin_exp_t e;
        e.id = 2'(i); e.cyc = c; e.mask = m; e.pins = p; e.a = a;
        pin_q.push_back(e);
    endtask

    // Presents a request in the cycle after the next rising edge; c0 is that
    // cycle's number (cycle 0 of the transaction).
    task automatic start(input int i, input logic w, input logic [21:0] a,
                         input logic [1:0] b, input logic [15:0] d, output logic [31:0] c0);
        @(posedge clk); #1;
        we[i] = w; addr[i] = a; be[i] = b; wr_data[i] = d;
        sel[i] = 1'b1; req[i] = 1'b1;
        c0 = cyc;
    endtask

    // Drops req in cycle 1, then lets the transaction run out.
    task automatic finish_txn(input int i, input int n);
        @(posedge clk); #1;
        req[i] = 1'b0; sel[i] = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Monitor: pops expected acks and pin values and compares them.
    always @(negedge clk) begin : monitor
        ack_exp_t ea;
        pin_exp_t ep;
        logic [6:0] act;
        while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            ea = ack_q.pop_front();
            checks++; errors++;
            $display("FAIL ack_missing inst%0d: no ack seen, required ack in cycle %0d", ea.id, ea.cyc);
        end
        for (int i = 0; i < 3; i++) begin
            if (ack[i]) begin
                checks++;
                if (ack_q.size() == 0 || ack_q[0].id != 2'(i)) begin
                    errors++;
                    $display("FAIL ack_unexpected inst%0d: ack=1 in cycle %0d, required none", i, cyc);
                end else if (ack_q[0].cyc != cyc) begin
                    ea = ack_q.pop_front();
                    errors++;
                    $display("FAIL ack_cycle inst%0d: ack in cycle %0d, required cycle %0d", i, cyc, ea.cyc);
                end else begin
                    ea = ack_q.pop_front();
                    if (ea.is_rd) begin
                        checks++;
                        if (rd_data[i] !== ea.data) begin
                            errors++;
                            $display("FAIL rd_data inst%0d: got %h, required %h", i, rd_data[i], ea.data);
                        end
                    end
                end
            end
        end
        while (pin_q.size() > 0 && pin_q[0].cyc <= cyc) begin
            ep = pin_q.pop_front();
            act = {sram_ce_n[ep.id], sram_oe_n[ep.id], sram_we_n[ep.id], sram_ub_n[ep.id],
                   sram_lb_n[ep.id], sram_d_oe[ep.id], busy[ep.id]};
            checks++;
            if ((act & ep.mask[6:0]) !== (ep.pins & ep.mask[6:0]) || ep.cyc != cyc) begin
                errors++;
                $display("FAIL pins inst%0d cyc%0d: got %b, required %b (mask %b, ce oe we ub lb doe busy)",
                         ep.id, ep.cyc, act, ep.pins, ep.mask[6:0]);
            end
            if (ep.mask[7]) begin
                checks++;
                if (sram_a[ep.id] !== ep.a) begin
                    errors++;
                    $display("FAIL sram_a inst%0d cyc%0d: got %h, required %h", ep.id, ep.cyc, sram_a[ep.id], ep.a);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] c0;
        logic [31:0] c1;
        rst = 1'b1;
        sel = '0; req = '0; we = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; be[i] = '0; wr_data[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values on all instances.
        for (int i = 0; i < 3; i++) push_pin(i, cyc, M_ALL, pv(1, 1, 1, 1, 1, 0, 0), 20'h0);

        // req with sel=0 is ignored for 20 cycles.
        @(posedge clk); #1;
        req[0] = 1'b1; sel[0] = 1'b0; we[0] = 1'b1; addr[0] = 22'h00_0010;
        for (int k = 0; k < 20; k++) push_pin(0, cyc + k, M_PINS, pv(1, 1, 1, 1, 1, 0, 0), 20'h0);
        repeat (20) @(posedge clk);
        #1 req[0] = 1'b0;

        // Full write, WR_WS=1: we_n low only in cycle 2, d_oe 1..3, ack 3.
        start(0, 1'b1, 22'h00_1234, 2'b11, 16'hA55A, c0);
        push_ack(0, c0 + 3, 1'b0, 16'h0);
        for (int k = 1; k <= 3; k++)
            push_pin(0, c0 + k, M_ALL, pv(0, 1, (k == 2) ? 1'b0 : 1'b1, 0, 0, 1, 1), 20'h01234);
        push_pin(0, c0 + 4, M_PINS, pv(1, 1, 1, 1, 1, 0, 0), 20'h0);
        finish_txn(0, 5);

        // Read back, RD_WS=1: oe_n low 1..2, ack 3 with A55A.
        start(0, 1'b0, 22'h00_1234, 2'b00, 16'h0, c0);
        push_ack(0, c0 + 3, 1'b1, 16'hA55A);
        for (int k = 1; k <= 2; k++)
            push_pin(0, c0 + k, M_ALL, pv(0, 0, 1, 0, 0, 0, 1), 20'h01234);
        push_pin(0, c0 + 3, 8'hB3, pv(0, 1, 1, 0, 0, 0, 1), 20'h01234);
        push_pin(0, c0 + 4, M_PINS, pv(1, 1, 1, 1, 1, 0, 0), 20'h0);
        finish_txn(0, 5);

        // Byte writes: 1111, then BEEF on the upper lane only -> BE11.
        start(0, 1'b1, 22'h00_0040, 2'b11, 16'h1111, c0);
        push_ack(0, c0 + 3, 1'b0, 16'h0);
        finish_txn(0, 5);
        start(0, 1'b1, 22'h00_0040, 2'b10, 16'hBEEF, c0);
        push_ack(0, c0 + 3, 1'b0, 16'h0);
        push_pin(0, c0 + 2, 8'h1C, pv(0, 0, 0, 0, 1, 0, 0), 20'h0);
        finish_txn(0, 5);
        start(0, 1'b0, 22'h00_0040, 2'b11, 16'h0, c0);
        push_ack(0, c0 + 3, 1'b1, 16'hBE11);
        finish_txn(0, 5);

        // be=00: full sequence with both lanes off, still acks, no change.
        start(0, 1'b1, 22'h00_0040, 2'b00, 16'h0000, c0);
        push_ack(0, c0 + 3, 1'b0, 16'h0);
        push_pin(0, c0 + 2, 8'h5E, pv(0, 0, 0, 1, 1, 1, 0), 20'h0);
        finish_txn(0, 5);
        start(0, 1'b0, 22'h00_0040, 2'b11, 16'h0, c0);
        push_ack(0, c0 + 3, 1'b1, 16'hBE11);
        finish_txn(0, 5);

        // Back-to-back on u1 (WR_WS=2, RD_WS=3) with req held high:
        // write ack 4, read accepted in 5, read ack 10.
        start(1, 1'b1, 22'h00_0055, 2'b11, 16'hC0DE, c0);
        push_ack(1, c0 + 4, 1'b0, 16'h0);
        push_ack(1, c0 + 10, 1'b1, 16'hC0DE);
        for (int k = 1; k <= 11; k++)
            push_pin(1, c0 + k, 8'h31,
                     pv(1, (k >= 6 && k <= 9) ? 1'b0 : 1'b1, (k == 2 || k == 3) ? 1'b0 : 1'b1,
                        1, 1, 0, ((k >= 1 && k <= 4) || (k >= 6 && k <= 10)) ? 1'b1 : 1'b0),
                     20'h0);
        @(posedge clk); #1;
        we[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1 req[1] = 1'b0; sel[1] = 1'b0;
        repeat (8) @(posedge clk);

        // Reset in cycle 2 of a WR_WS=4 write on u2: pins released in
        // cycle 3, no ack; a read issued in cycle 3 is accepted at once.
        start(2, 1'b1, 22'h00_0066, 2'b11, 16'h1234, c0);
        push_pin(2, c0 + 2, 8'h53, pv(0, 0, 0, 0, 0, 1, 1), 20'h0);
        push_pin(2, c0 + 3, M_ALL, pv(1, 1, 1, 1, 1, 0, 0), 20'h0);
        @(posedge clk); #1;
        req[2] = 1'b0; sel[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        we[2] = 1'b0; addr[2] = 22'h00_0077; sel[2] = 1'b1; req[2] = 1'b1;
        c1 = cyc;
        push_ack(2, c1 + 3, 1'b1, 16'h0000);
        push_pin(2, c1 + 1, M_ALL, pv(0, 0, 1, 0, 0, 0, 1), 20'h00077);
        finish_txn(2, 8);

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
